// File: rtl/nes_vga_scaler_pkg.sv
// nes_vga_pkg: shared constants for the NES-to-VGA scaler.
//   NES_PALETTE : 64-entry 12-bit RGB palette ROM ({r,g,b}, 4 bits each)
//   WIN_W/WIN_H : size of the 2x-scaled window in VGA pixels
//   FETCH_*     : v_cnt values that trigger line fetches
//   fetch_state_t : line-fetch FSM encoding
package nes_vga_pkg;

  localparam int WIN_W = 512;
  localparam int WIN_H = 480;

  localparam logic [9:0] FETCH_LINE0_V = 10'd522;
  localparam logic [9:0] FETCH_LAST_V  = 10'd476;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_t;

  localparam logic [11:0] NES_PALETTE [0:63] = '{
    12'h666, 12'h02A, 12'h11B, 12'h30A, 12'h507, 12'h604, 12'h600, 12'h420,
    12'h230, 12'h040, 12'h040, 12'h031, 12'h035, 12'h000, 12'h000, 12'h000,
    12'hAAA, 12'h15E, 12'h43F, 12'h72F, 12'hA1C, 12'hB16, 12'hB30, 12'h950,
    12'h670, 12'h380, 12'h090, 12'h074, 12'h067, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h6AF, 12'h98F, 12'hC7F, 12'hF6F, 12'hF6B, 12'hF86, 12'hEA4,
    12'hBC3, 12'h8D4, 12'h5E7, 12'h4DB, 12'h4CD, 12'h444, 12'h000, 12'h000,
    12'hFFF, 12'hBDF, 12'hCCF, 12'hEBF, 12'hFBF, 12'hFBE, 12'hFCB, 12'hFDA,
    12'hEE9, 12'hCF9, 12'hAFB, 12'h9FE, 12'h9EF, 12'hBBB, 12'h000, 12'h000
  };

endpackage

// File: rtl/nes_vga_scaler_line_buffer.sv
// nes_line_buffer: two 256x6 line banks in one 512x6 RAM.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : {bank, x} write address
//   wr_data : palette index to store
//   rd_addr : {bank, x} read address
//   rd_data : registered read data (one cycle after rd_addr)
// No reset on the array or read register so that it maps onto RAM.
module nes_line_buffer (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [8:0] wr_addr,
  input  logic [5:0] wr_data,
  input  logic [8:0] rd_addr,
  output logic [5:0] rd_data
);

  logic [5:0] mem [0:511];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/nes_vga_scaler.sv
// nes_vga_scaler: fetches NES frame-buffer lines into ping-pong line
// buffers and emits a 2x-scaled, horizontally centred 12-bit RGB stream.
//   clk, rst          : pixel clock, async active-high reset
//   h_cnt, v_cnt      : timing-generator position
//   h_sync, v_sync    : active-low syncs in; blank: 1 = not visible
//   fb_req, fb_addr   : line-fetch request and {nes_y, nes_x} address
//   fb_ack, fb_data   : fetch acknowledge and palette index
//   vga_r/g/b         : pixel colour, 2 cycles behind the inputs
//   vga_hs, vga_vs    : syncs delayed 2 cycles to match the colour path
//   underrun          : sticky, a fetch was still running at next trigger
module nes_vga_scaler
  import nes_vga_pkg::*;
#(
  parameter logic [11:0] BORDER_RGB = 12'h000,
  parameter logic [9:0]  H_START    = 10'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        blank,
  output logic        fb_req,
  output logic [15:0] fb_addr,
  input  logic        fb_ack,
  input  logic [5:0]  fb_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        underrun
);

  fetch_state_t state, state_nxt;
  logic [7:0]   x_q, x_nxt, y_q, y_nxt;
  logic         underrun_nxt;
  logic         trig;
  logic [7:0]   trig_line;
  logic         wr_en;

  // Line 0 is fetched during vertical blank; every even visible line
  // fetches the NES line shown on the next pair of VGA lines.
  always_comb begin
    trig      = 1'b0;
    trig_line = 8'd0;
    if (h_cnt == 10'd0) begin
      if (v_cnt == FETCH_LINE0_V) begin
        trig = 1'b1;
      end else if (!v_cnt[0] && (v_cnt <= FETCH_LAST_V)) begin
        trig      = 1'b1;
        trig_line = v_cnt[8:1] + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    x_nxt        = x_q;
    y_nxt        = y_q;
    underrun_nxt = underrun;
    wr_en        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig) begin
          state_nxt = ST_FETCH;
          x_nxt     = 8'd0;
          y_nxt     = trig_line;
        end
      end
      ST_FETCH: begin
        if (fb_ack) begin
          wr_en = 1'b1;
          x_nxt = x_q + 8'd1;
          if (x_q == 8'hFF) state_nxt = ST_IDLE;
        end
        // A late trigger abandons the current line; the acked word above
        // is still written before the restart.
        if (trig) begin
          underrun_nxt = 1'b1;
          state_nxt    = ST_FETCH;
          x_nxt        = 8'd0;
          y_nxt        = trig_line;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      x_q      <= 8'd0;
      y_q      <= 8'd0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      underrun <= underrun_nxt;
    end
  end

  assign fb_req  = (state == ST_FETCH);
  assign fb_addr = {y_q, x_q};

  // Window decode: unsigned 10-bit offset from H_START, halved for nes_x.
  logic [9:0] h_off;
  logic       in_win;
  logic [5:0] pix_idx;

  assign h_off  = h_cnt - H_START;
  assign in_win = (h_cnt >= H_START) && (h_off < 10'(WIN_W)) &&
                  (v_cnt < 10'(WIN_H));

  nes_line_buffer u_line_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({y_q[0], x_q}),
    .wr_data (fb_data),
    .rd_addr ({v_cnt[1], h_off[8:1]}),
    .rd_data (pix_idx)
  );

  logic        win_d1, blank_d1;
  logic        hs_d1, vs_d1;
  logic [11:0] rgb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_d1   <= 1'b0;
      blank_d1 <= 1'b1;
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
      vga_hs   <= 1'b1;
      vga_vs   <= 1'b1;
      rgb      <= 12'h000;
    end else begin
      win_d1   <= in_win;
      blank_d1 <= blank;
      hs_d1    <= h_sync;
      vs_d1    <= v_sync;
      vga_hs   <= hs_d1;
      vga_vs   <= vs_d1;
      if (blank_d1)     rgb <= 12'h000;
      else if (!win_d1) rgb <= BORDER_RGB;
      else              rgb <= NES_PALETTE[pix_idx];
    end
  end

  assign vga_r = rgb[11:8];
  assign vga_g = rgb[7:4];
  assign vga_b = rgb[3:0];

endmodule

// File: tb/tb_nes_vga_scaler.sv
`timescale 1ns/1ps
module tb_nes_vga_scaler;
  import nes_vga_pkg::*;

  localparam logic [11:0] BORDER = 12'h5A3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  h_cnt, v_cnt;
  logic        h_sync, v_sync, blank;
  logic        fb_req;
  logic [15:0] fb_addr;
  logic        fb_ack;
  logic [5:0]  fb_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, underrun;

  always #5 clk = ~clk;

  nes_vga_scaler #(.BORDER_RGB(BORDER), .H_START(10'd64)) dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .h_sync(h_sync), .v_sync(v_sync), .blank(blank),
    .fb_req(fb_req), .fb_addr(fb_addr), .fb_ack(fb_ack), .fb_data(fb_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .underrun(underrun)
  );

  int checks = 0;
  int errors = 0;
  int h = 0, v = 0, mode = 0, cyc = 0, k = 0, n = 0;
  bit pix_chk = 0, rand_sync = 0, sync_low = 0;
  logic [5:0]  fbm  [0:65535];
  logic [5:0]  bank [0:1][0:255];
  logic [11:0] pipe_rgb [0:1];
  bit          pipe_ok  [0:1];
  logic        hist_hs  [0:1];
  logic        hist_vs  [0:1];
  bit          ack_taken;
  logic [15:0] ack_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int hh, input int vv, input logic bl);
    if (bl) return 12'h000;
    if (vv < 480 && hh >= 64 && hh < 576)
      return NES_PALETTE[bank[(vv >> 1) & 1][(hh - 64) >> 1]];
    return BORDER;
  endfunction

  // Present timing for (h,v), the expected colour, and the frame-buffer side.
  task automatic drive();
    logic hs, vs, bl;
    bl = (h >= 640) || (v >= 480);
    hs = !(h >= 656 && h < 752);
    vs = !(v >= 490 && v < 492);
    if (rand_sync) begin
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      bl = 1'($urandom_range(0, 1));
    end
    if (sync_low) begin
      hs = 1'b0;
      vs = 1'b0;
    end
    h_cnt = 10'(h); v_cnt = 10'(v);
    h_sync = hs; v_sync = vs; blank = bl;
    hist_hs[0] = hs; hist_vs[0] = vs;
    pipe_rgb[0] = exp_rgb(h, v, bl);
    pipe_ok[0]  = pix_chk;
    fb_ack = (mode == 1) || (mode == 2 && (cyc % 4) == 3) ||
             (mode == 3 && $urandom_range(0, 1) == 1);
    fb_data = fbm[fb_addr];
    ack_taken = fb_ack && fb_req;
    if (ack_taken) begin
      ack_addr = fb_addr;
      bank[fb_addr[8]][fb_addr[7:0]] = fb_data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("vga_hs", 32'(vga_hs), 32'(hist_hs[1]));
    chk("vga_vs", 32'(vga_vs), 32'(hist_vs[1]));
    if (pipe_ok[1]) chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(pipe_rgb[1]));
    hist_hs[1] = hist_hs[0]; hist_vs[1] = hist_vs[0];
    pipe_rgb[1] = pipe_rgb[0]; pipe_ok[1] = pipe_ok[0];
    h++;
    if (h == 800) begin
      h = 0;
      v++;
      if (v == 524) v = 0;
    end
    drive();
  endtask

  task automatic jump(input int hh, input int vv);
    h = hh; v = vv;
    drive();
  endtask

  task automatic point(input string tag, input int hh, input int vv, input logic [11:0] exp);
    jump(hh, vv);
    tick();
    tick();
    chk(tag, 32'({vga_r, vga_g, vga_b}), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) fbm[i] = 6'($urandom);
    for (int x = 0; x < 256; x++) fbm[(2 << 8) | x] = 6'(x & 63);
    h_cnt = 10'd700; v_cnt = 10'd500; h_sync = 1'b1; v_sync = 1'b1; blank = 1'b1;
    fb_ack = 1'b0; fb_data = 6'd0;
    hist_hs[0] = 1'b1; hist_hs[1] = 1'b1; hist_vs[0] = 1'b1; hist_vs[1] = 1'b1;
    pipe_ok[0] = 0; pipe_ok[1] = 0;

    // power-on reset, no clock edge yet
    #1 rst = 1'b1;
    #2;
    chk("rst_req", 32'(fb_req), 32'd0);
    chk("rst_addr", 32'(fb_addr), 32'd0);
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("rst_hs", 32'(vga_hs), 32'd1);
    chk("rst_vs", 32'(vga_vs), 32'd1);
    chk("rst_underrun", 32'(underrun), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    jump(700, 500);
    hist_hs[1] = 1'b1; hist_vs[1] = 1'b1;
    rst = 1'b0;
    repeat (3) tick();

    // zero-wait fetch of line 0
    mode = 1;
    jump(0, 522);
    tick();
    chk("zw_req_rise", 32'(fb_req), 32'd1);
    k = 0; n = 1;
    while (1) begin
      if (ack_taken) begin
        chk("zw_addr", 32'(ack_addr), 32'(k));
        k++;
      end
      if (k == 256 || n >= 300) break;
      tick();
      n++;
    end
    chk("zw_acks", 32'(k), 32'd256);
    chk("zw_cycles", 32'(n), 32'd256);
    tick();
    chk("zw_req_low", 32'(fb_req), 32'd0);
    chk("zw_underrun", 32'(underrun), 32'd0);

    // display line 0 (random data) on both VGA lines
    mode = 0; pix_chk = 1;
    jump(40, 0);
    repeat (660) tick();
    jump(50, 1);
    repeat (300) tick();
    pix_chk = 0;

    // wait-state fetch of line 2 (data = nes_x)
    mode = 2;
    jump(0, 2);
    k = 0; n = 0;
    while (1) begin
      tick();
      n++;
      if (fb_req !== 1'b1 || n > 1200) break;
      chk("ws_addr", 32'(fb_addr), 32'({8'd2, 8'(k)}));
      if (ack_taken) k++;
    end
    chk("ws_acks", 32'(k), 32'd256);
    chk("ws_duration", 32'(n >= 1020 && n <= 1030), 32'd1);
    chk("ws_underrun", 32'(underrun), 32'd0);

    // pixel mapping on line 2
    mode = 0; pix_chk = 1;
    jump(30, 4);
    repeat (700) tick();
    point("map_h64", 64, 5, NES_PALETTE[0]);
    point("map_h65", 65, 5, NES_PALETTE[0]);
    point("map_h66", 66, 4, NES_PALETTE[1]);
    point("map_h575", 575, 4, NES_PALETTE[63]);
    point("map_h63", 63, 5, BORDER);
    point("map_h576", 576, 5, BORDER);
    point("map_blank", 700, 4, 12'h000);
    pix_chk = 0;

    // random-ack fetch of line 3, then display it
    mode = 3;
    jump(0, 4);
    k = 0; n = 0;
    while (1) begin
      tick();
      n++;
      if (fb_req !== 1'b1 || n > 1590) break;
      chk("ra_addr", 32'(fb_addr), 32'({8'd3, 8'(k)}));
      if (ack_taken) k++;
    end
    chk("ra_acks", 32'(k), 32'd256);
    chk("ra_underrun", 32'(underrun), 32'd0);
    mode = 0; pix_chk = 1;
    jump(30, 6);
    repeat (700) tick();

    // random syncs and blank
    rand_sync = 1;
    jump(100, 10);
    repeat (400) tick();
    rand_sync = 0; pix_chk = 0;

    // underrun and trigger boundaries
    mode = 0;
    jump(0, 522);
    repeat (5) tick();
    chk("ur_req", 32'(fb_req), 32'd1);
    chk("ur_addr0", 32'(fb_addr), 32'h0000);
    chk("ur_clear", 32'(underrun), 32'd0);
    jump(0, 0);
    tick();
    chk("ur_set", 32'(underrun), 32'd1);
    chk("ur_addr1", 32'(fb_addr), 32'h0100);
    chk("ur_req_hold", 32'(fb_req), 32'd1);
    mode = 1; n = 0;
    while (fb_req === 1'b1 && n < 400) begin tick(); n++; end
    chk("ur_done", 32'(fb_req), 32'd0);
    chk("ur_sticky1", 32'(underrun), 32'd1);
    jump(0, 478);
    tick();
    chk("no_trig_478", 32'(fb_req), 32'd0);
    jump(0, 3);
    tick();
    chk("no_trig_odd", 32'(fb_req), 32'd0);
    jump(5, 2);
    tick();
    chk("no_trig_h5", 32'(fb_req), 32'd0);
    jump(0, 476);
    tick();
    chk("trig_476_req", 32'(fb_req), 32'd1);
    chk("trig_476_addr", 32'(fb_addr), 32'hEF00);
    n = 0;
    while (fb_req === 1'b1 && n < 400) begin tick(); n++; end
    chk("trig_476_done", 32'(fb_req), 32'd0);
    mode = 0;
    jump(0, 522);
    tick();
    chk("ur_sticky2", 32'(underrun), 32'd1);
    chk("ur_frame_addr", 32'(fb_addr), 32'h0000);

    // asynchronous reset mid-fetch with syncs low and border colour showing
    sync_low = 1; pix_chk = 1;
    jump(10, 10);
    repeat (3) tick();
    chk("pre_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'(BORDER));
    chk("pre_rst_req", 32'(fb_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", 32'(fb_req), 32'd0);
    chk("arst_addr", 32'(fb_addr), 32'd0);
    chk("arst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("arst_hs", 32'(vga_hs), 32'd1);
    chk("arst_vs", 32'(vga_vs), 32'd1);
    chk("arst_underrun", 32'(underrun), 32'd0);
    sync_low = 0; pix_chk = 0;
    pipe_ok[0] = 0; pipe_ok[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    jump(700, 500);
    hist_hs[1] = 1'b1; hist_vs[1] = 1'b1;
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_req", 32'(fb_req), 32'd0);
    chk("post_rst_underrun", 32'(underrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_vga_scaler.md
# nes_vga_scaler

Pixel stage directly downstream of the 640x480@60 Hz VGA timing generator. It consumes the timing generator's counters, syncs and blank, and fetches NES frame-buffer lines (256x240, 6-bit palette indices) over a request/acknowledge port into ping-pong line buffers. It then outputs 2x-scaled, horizontally centred 12-bit RGB, with syncs delayed to stay aligned with the pixel pipeline.

## Interface
Parameters:
- BORDER_RGB, 12'h000, colour driven inside the active area but outside the 512x480 window.
- H_START, 10'd64, first h_cnt of the scaled window; the window spans H_START..H_START+511.

Ports:
- clk  in  1  pixel clock, shared with the timing generator.
- rst  in  1  reset; asynchronous, active-high.
- h_cnt  in  10  timing-generator X (0..799).
- v_cnt  in  10  timing-generator Y (0..523).
- h_sync  in  1  active-low horizontal sync from the timing generator.
- v_sync  in  1  active-low vertical sync from the timing generator.
- blank  in  1  timing-generator blank; 1 = outside the visible area.
- fb_req  out  1  line-fetch request, held high until acknowledged.
- fb_addr  out  16  {nes_y[7:0], nes_x[7:0]}; stable while fb_req is high.
- fb_ack  in  1  frame-buffer acknowledge; fb_data is valid in this cycle.
- fb_data  in  6  palette index.
- vga_r, vga_g, vga_b  out  4 each  pixel colour.
- vga_hs, vga_vs  out  1 each  delayed syncs.
- underrun  out  1  sticky flag: a line fetch did not complete in time. Cleared only by rst.

## Operation
- Mapping inside the window: nes_x = (h_cnt-H_START)>>1, nes_y = v_cnt>>1. Each NES pixel is shown as 2x2 VGA pixels.
- Ping-pong buffers: two 256x6 buffers. The display reads buffer nes_y[0]; a fetch of line L writes buffer L[0].
- Fetch triggers, evaluated at h_cnt==0:
  - v_cnt==522: fetch line 0.
  - Even v_cnt 0..476: fetch line (v_cnt>>1)+1.
  - No fetch at v_cnt 478.
  - Each fetch therefore has 1600 cycles to move 256 words.
- Fetch FSM states: IDLE, FETCH.
  - IDLE -> FETCH on a trigger. Load nes_y from the trigger, set x=0, assert fb_req.
  - In FETCH, each fb_ack writes fb_data to buf[y[0]][x] and increments x.
  - On the ack with x==255, go to IDLE; fb_req is low from the next cycle.
  - A trigger arriving while in FETCH sets underrun and restarts FETCH for the new line with x=0. If the trigger coincides with an ack, that word is still written, then the restart takes effect.
  - fb_ack is ignored while in IDLE.
- Colour selection:
  - blank=1 gives RGB 0.
  - Active area outside the window gives BORDER_RGB.
  - Otherwise the colour is palette[buf[nes_y[0]][nes_x]].
- Reset mid-fetch: the FSM returns to IDLE and fb_req drops asynchronously. Buffer contents are undefined until refetched.

## Timing
- Reset values: fb_req=0, fb_addr=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, underrun=0, FSM=IDLE, x=0.
- Pixel pipeline latency is 2 cycles:
  - Stage 1: registered line-buffer read plus the registered window/blank decode.
  - Stage 2: registered palette ROM.
  - Inputs sampled at cycle n appear on the outputs at n+2.
- h_sync, v_sync and blank pass through a 2-stage delay, so vga_hs and vga_vs are exactly 2 cycles behind h_sync and v_sync.
- fb_req rises 1 cycle after the trigger cycle. A new fb_addr is presented the cycle after each ack. Back-to-back acks (one per cycle) are supported, giving a fetch of at least 256 cycles.
- Arithmetic: the window compare and subtract use 10-bit unsigned values; nes_x takes bits [8:1] of the difference.

## Structure
- Package nes_vga_pkg holds:
  - the 64-entry 12-bit NES palette ROM constant;
  - window constants (width 512, height 480);
  - fetch trigger lines (522, last trigger at v_cnt 476);
  - the FSM state encoding.
- Sub-module nes_line_buffer: two 256x6 banks with one synchronous write port and one registered read port; bank select is the top address bit. It must infer block/distributed RAM.

## Test plan
- Reset: assert rst mid-frame -> fb_req=0, RGB=0, vga_hs=vga_vs=1 and underrun=0 immediately, with no clock edge required.
- Zero-wait fetch:
  - Stimulus: at v_cnt=522, h_cnt=0, hold fb_ack=1.
  - Response: fb_req rises next cycle; exactly 256 acks occur with fb_addr 16'h0000..16'h00FF; fb_req is low the cycle after the ack at 16'h00FF.
- Wait-state handshake: ack every 4th cycle -> fb_addr is held stable between acks; the fetch completes in 1024 cycles with no underrun.
- Pixel mapping:
  - Stimulus: frame-buffer word = nes_x for every line.
  - Response: h_cnt 64 and 65 each give palette[0] two cycles later; h_cnt 66 gives palette[1]; h_cnt 575 gives palette[255&63]; h_cnt 63 and 576 give BORDER_RGB; while blank=1 the output is RGB 0.
- Underrun: never ack -> at the next trigger (v_cnt=0, h_cnt=0) underrun=1, fb_addr shows line 1 with x=0, and underrun stays 1 through later frames.
- Sync alignment: over a full frame, vga_hs and vga_vs equal h_sync and v_sync delayed by exactly 2 cycles.
